// File: rtl/run_ctrl_sro.sv
// run_ctrl_sro: host-side run controller for the SRO core.
// It owns the core start line and owns the data-memory port while the core is parked.
// It observes core halt and exposes one valid/ready command channel.
// Over that channel the host preloads dmem, launches a program, times it, and reads results back.
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   cmd_valid_i/ready_o    command handshake; op 00 WRITE, 01 READ, 10 RUN, 11 CLEAR
//   cmd_op_i/addr_i/data_i command payload
//   abort_i                host abort of PRIME/RUN
//   rsp_valid_o/ready_i    read response handshake, rsp_data_o payload
//   core_start_o           core start_tp (1 = PC held at start)
//   core_halt_i            core halt_tp
//   dm_own_o               1 = controller drives dmem, 0 = core drives it
//   dm_addr_o/wdata_o/we_o/re_o, dm_rdata_i   dmem port (rdata combinational from addr)
//   busy_o, done_o, timeout_o, cycle_count_o  status
module run_ctrl_sro #(
   parameter int unsigned ADDR_W         = 8,
   parameter int unsigned DATA_W         = 8,
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned START_CYCLES   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 32'h0000_FFFF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [1:0]        cmd_op_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_data_i,
   input  logic              abort_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              core_start_o,
   input  logic              core_halt_i,
   output logic              dm_own_o,
   output logic [ADDR_W-1:0] dm_addr_o,
   output logic [DATA_W-1:0] dm_wdata_o,
   output logic              dm_we_o,
   output logic              dm_re_o,
   input  logic [DATA_W-1:0] dm_rdata_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              timeout_o,
   output logic [CNT_W-1:0]  cycle_count_o
);

   localparam int unsigned PRIME_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(START_CYCLES - 1);
   localparam bit                 TO_EN      = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_RUN   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_RSP,
      S_PRIME,
      S_RUN
   } state_e;

   state_e              state_q, state_d;
   logic [PRIME_W-1:0]  prime_cnt_q, prime_cnt_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                done_q, done_d;
   logic                timeout_q, timeout_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                core_start_q, core_start_d;
   logic                dm_own_q, dm_own_d;
   logic                dm_we_q, dm_we_d;
   logic                dm_re_q, dm_re_d;
   logic                busy_q, busy_d;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d      = state_q;
      prime_cnt_d  = prime_cnt_q;
      count_d      = count_q;
      done_d       = done_q;
      timeout_d    = timeout_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rsp_data_d   = rsp_data_q;

      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               unique case (cmd_op_i)
                  OP_WRITE: begin
                     addr_d  = cmd_addr_i;
                     wdata_d = cmd_data_i;
                     state_d = S_WR;
                  end
                  OP_READ: begin
                     addr_d  = cmd_addr_i;
                     state_d = S_RD;
                  end
                  OP_RUN: begin
                     prime_cnt_d = '0;
                     count_d     = '0;
                     done_d      = 1'b0;
                     timeout_d   = 1'b0;
                     state_d     = S_PRIME;
                  end
                  OP_CLEAR: begin
                     count_d   = '0;
                     done_d    = 1'b0;
                     timeout_d = 1'b0;
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_WR: state_d = S_IDLE;
         S_RD: begin
            rsp_data_d = dm_rdata_i;
            state_d    = S_RSP;
         end
         S_RSP: begin
            if (rsp_ready_i) state_d = S_IDLE;
         end
         S_PRIME: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (prime_cnt_q == PRIME_LAST) begin
               state_d = S_RUN;
            end else begin
               prime_cnt_d = prime_cnt_q + PRIME_W'(1);
            end
         end
         S_RUN: begin
            // Abort leaves the count as it stood before the abort cycle
            if (abort_i) begin
               done_d    = 1'b0;
               timeout_d = 1'b0;
               state_d   = S_IDLE;
            end else begin
               count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
               // count_q == 0 only in the first RUN cycle, where halt may be stale
               if (core_halt_i && (count_q != '0)) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else if (TO_EN && (count_q == TO_LAST)) begin
                  timeout_d = 1'b1;
                  state_d   = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Moore outputs decoded from the next state so they register in step with it
      cmd_ready_d  = (state_d == S_IDLE);
      rsp_valid_d  = (state_d == S_RSP);
      core_start_d = (state_d != S_RUN);
      dm_own_d     = (state_d == S_WR) || (state_d == S_RD);
      dm_we_d      = (state_d == S_WR);
      dm_re_d      = (state_d == S_RD);
      busy_d       = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         prime_cnt_q  <= '0;
         count_q      <= '0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rsp_data_q   <= '0;
         cmd_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         core_start_q <= 1'b1;
         dm_own_q     <= 1'b0;
         dm_we_q      <= 1'b0;
         dm_re_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         prime_cnt_q  <= prime_cnt_d;
         count_q      <= count_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rsp_data_q   <= rsp_data_d;
         cmd_ready_q  <= cmd_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         core_start_q <= core_start_d;
         dm_own_q     <= dm_own_d;
         dm_we_q      <= dm_we_d;
         dm_re_q      <= dm_re_d;
         busy_q       <= busy_d;
      end
   end

   assign cmd_ready_o   = cmd_ready_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_data_o    = rsp_data_q;
   assign core_start_o  = core_start_q;
   assign dm_own_o      = dm_own_q;
   assign dm_addr_o     = addr_q;
   assign dm_wdata_o    = wdata_q;
   assign dm_we_o       = dm_we_q;
   assign dm_re_o       = dm_re_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign timeout_o     = timeout_q;
   assign cycle_count_o = count_q;

endmodule

// File: tb/tb_run_ctrl_sro.sv
// tb_run_ctrl_sro: self-checking bench for run_ctrl_sro.
// It includes a dmem model and a host-driven core halt line.
// Reference checking uses a memory scoreboard and an event-ordering model of each RUN.
module tb_run_ctrl_sro;

   localparam int unsigned START_CYC = 2;
   localparam int unsigned TO_CYC    = 40;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_RUN   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [7:0]  cmd_addr = 8'h00;
   logic [7:0]  cmd_data = 8'h00;
   logic        abort = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [7:0]  rsp_data;
   logic        core_start;
   logic        core_halt = 1'b0;
   logic        dm_own;
   logic [7:0]  dm_addr;
   logic [7:0]  dm_wdata;
   logic        dm_we;
   logic        dm_re;
   logic [7:0]  dm_rdata;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [15:0] cycle_count;

   int n_checks = 0;
   int n_fail   = 0;
   int we_cnt   = 0;

   logic [7:0] mem     [256];
   logic [7:0] exp_mem [256];

   always #5 clk = ~clk;

   run_ctrl_sro #(
      .ADDR_W(8), .DATA_W(8), .CNT_W(16),
      .START_CYCLES(START_CYC), .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
      .abort_i(abort),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
      .core_start_o(core_start), .core_halt_i(core_halt),
      .dm_own_o(dm_own), .dm_addr_o(dm_addr), .dm_wdata_o(dm_wdata),
      .dm_we_o(dm_we), .dm_re_o(dm_re), .dm_rdata_i(dm_rdata),
      .busy_o(busy), .done_o(done), .timeout_o(timeout),
      .cycle_count_o(cycle_count)
   );

   // dmem: combinational read, synchronous write
   assign dm_rdata = mem[dm_addr];
   always @(posedge clk) begin
      if (dm_we) begin
         mem[dm_addr] <= dm_wdata;
         we_cnt       <= we_cnt + 1;
      end
   end

   // Port-safety rules checked every cycle
   always @(negedge clk) begin
      n_checks++;
      if (((dm_we || dm_re) && !dm_own) || (dm_we && dm_re)) begin
         n_fail++;
         $display("FAIL dm_port_rule: we=%0b re=%0b own=%0b required no access without ownership",
                  dm_we, dm_re, dm_own);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
      int w = 0;
      while (!cmd_ready && w < 100) begin
         step();
         w++;
      end
      check("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_data  = d;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      int we0 = we_cnt;
      send_cmd(OP_WRITE, a, d);
      check("wr_we", 32'(dm_we), 32'd1);
      check("wr_own", 32'(dm_own), 32'd1);
      check("wr_addr", 32'(dm_addr), 32'(a));
      check("wr_data", 32'(dm_wdata), 32'(d));
      check("wr_cmd_ready", 32'(cmd_ready), 32'd0);
      step();
      check("wr_we_pulses", 32'(we_cnt - we0), 32'd1);
      check("wr_back_idle", 32'(busy), 32'd0);
      exp_mem[a] = d;
   endtask

   task automatic do_read(input logic [7:0] a, input int hold, input logic [7:0] exp);
      send_cmd(OP_READ, a, 8'h00);
      check("rd_re", 32'(dm_re), 32'd1);
      check("rd_own", 32'(dm_own), 32'd1);
      check("rd_we", 32'(dm_we), 32'd0);
      step();
      for (int i = 0; i < hold; i++) begin
         check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
         check("rsp_data_hold", 32'(rsp_data), 32'(exp));
         check("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_data", 32'(rsp_data), 32'(exp));
      step();
      rsp_ready = 1'b0;
      check("rsp_released", 32'(rsp_valid), 32'd0);
      check("rsp_back_idle", 32'(cmd_ready), 32'd1);
   endtask

   // Run with halt raised in RUN cycle h (0 = never), abort in RUN cycle a (0 = never),
   // optional stale halt held through PRIME and RUN cycle 1.
   task automatic do_run(input int h, input int a, input bit stale);
      int exp_cnt;
      bit exp_done;
      bit exp_to;
      int best;
      int prime_hi = 0;
      int r = 0;
      // Earliest event ends the run; abort beats halt beats timeout on a tie.
      // Halt only counts from RUN cycle 2.
      best     = 1 << 30;
      exp_cnt  = 0;
      exp_done = 1'b0;
      exp_to   = 1'b0;
      if (a > 0) begin
         best = a; exp_cnt = a - 1;
      end
      if (h >= 2 && h < best) begin
         best = h; exp_cnt = h; exp_done = 1'b1;
      end
      if (TO_CYC != 0 && int'(TO_CYC) < best) begin
         best = int'(TO_CYC); exp_cnt = int'(TO_CYC); exp_to = 1'b1; exp_done = 1'b0;
      end

      send_cmd(OP_RUN, 8'h00, 8'h00);
      check("prime_done_clr", 32'(done), 32'd0);
      check("prime_to_clr", 32'(timeout), 32'd0);
      check("prime_cnt_clr", 32'(cycle_count), 32'd0);
      for (int i = 0; i < 200; i++) begin
         if (!busy) break;
         if (core_start) prime_hi++;
         else r++;
         core_halt = (stale && r <= 1) || (h != 0 && r == h);
         abort     = (a != 0 && r == a);
         step();
      end
      core_halt = 1'b0;
      abort     = 1'b0;
      check("run_ended", 32'(busy), 32'd0);
      check("start_high_cycles", 32'(prime_hi), 32'(START_CYC));
      check("run_done", 32'(done), 32'(exp_done));
      check("run_timeout", 32'(timeout), 32'(exp_to));
      check("run_count", 32'(cycle_count), 32'(exp_cnt));
      check("run_reparked", 32'(core_start), 32'd1);
      check("run_dm_own", 32'(dm_own), 32'd0);
   endtask

   typedef struct {
      bit         is_rd;
      logic [7:0] addr;
      logic [7:0] data;
      int         hold;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{1'b0, 8'h10, 8'hA5, 0};
      tbl[1] = '{1'b1, 8'h10, 8'hA5, 3};
      tbl[2] = '{1'b0, 8'h00, 8'h3C, 0};
      tbl[3] = '{1'b0, 8'hFF, 8'hC3, 0};
      tbl[4] = '{1'b1, 8'hFF, 8'hC3, 0};
      tbl[5] = '{1'b1, 8'h00, 8'h3C, 1};
      tbl[6] = '{1'b0, 8'h10, 8'h5A, 0};
      tbl[7] = '{1'b1, 8'h10, 8'h5A, 2};

      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'h00;
         exp_mem[i] = 8'h00;
      end

      // Reset
      rst_n = 1'b0;
      step();
      step();
      check("rst_core_start", 32'(core_start), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_dm_own", 32'(dm_own), 32'd0);
      check("rst_count", 32'(cycle_count), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      rst_n = 1'b1;
      step();

      // Write/read vectors
      foreach (tbl[i]) begin
         if (tbl[i].is_rd) do_read(tbl[i].addr, tbl[i].hold, tbl[i].data);
         else              do_write(tbl[i].addr, tbl[i].data);
      end

      // Halt after 37 RUN cycles
      do_run(37, 0, 1'b0);
      // No halt: timeout, then CLEAR
      do_run(0, 0, 1'b0);
      send_cmd(OP_CLEAR, 8'h00, 8'h00);
      check("clr_done", 32'(done), 32'd0);
      check("clr_timeout", 32'(timeout), 32'd0);
      check("clr_count", 32'(cycle_count), 32'd0);
      check("clr_busy", 32'(busy), 32'd0);
      // Stale halt ignored, later re-raised; stale halt alone runs to timeout
      do_run(12, 0, 1'b1);
      do_run(0, 0, 1'b1);
      // Halt exactly on the timeout cycle
      do_run(int'(TO_CYC), 0, 1'b0);
      // Halt in RUN cycle 2, the earliest honoured
      do_run(2, 0, 1'b0);
      // Abort mid-RUN freezes the count
      do_run(0, 15, 1'b0);

      // Reset mid-RUN
      send_cmd(OP_RUN, 8'h00, 8'h00);
      for (int i = 0; i < int'(START_CYC) + 10; i++) step();
      check("midrun_count", 32'(cycle_count), 32'd10);
      check("midrun_start_low", 32'(core_start), 32'd0);
      rst_n = 1'b0;
      step();
      check("midrst_start", 32'(core_start), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_count", 32'(cycle_count), 32'd0);
      check("midrst_dm_own", 32'(dm_own), 32'd0);
      rst_n = 1'b1;
      step();

      // Randomized mix against the scoreboard and run model
      for (int it = 0; it < 40; it++) begin
         int sel = int'($urandom_range(0, 3));
         logic [7:0] ra = 8'($urandom_range(0, 255));
         logic [7:0] rd = 8'($urandom_range(0, 255));
         case (sel)
            0: do_write(ra, rd);
            1: do_read(ra, int'($urandom_range(0, 3)), exp_mem[ra]);
            2: begin
               int h = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 50));
               int a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 50)) : 0;
               do_run(h, a, 1'($urandom_range(0, 1)));
            end
            default: begin
               send_cmd(OP_CLEAR, 8'h00, 8'h00);
               check("rclr_done", 32'(done), 32'd0);
               check("rclr_count", 32'(cycle_count), 32'd0);
            end
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
